// File: rtl/fft_pkg.sv
// Shared definitions for the DFT sequencer: sequencer states, address width
// and the default MAC datapath latency.
package fft_pkg;

  localparam int ADDR_W      = 12;
  localparam int MAC_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COMPUTE,
    ST_DRAIN,
    ST_WRITE
  } state_e;

endpackage

// File: rtl/dft_sequencer_tw_adr_gen.sv
// Twiddle index generator: walks tw = (n*k) mod N one step per sample using a
// single add and a conditional subtract, so no multiplier or divider is needed.
// Since k < N and tw < N, the sum is below 2N and one subtract always suffices.
module tw_adr_gen
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] k,
  input  logic [ADDR_W-1:0] N,
  output logic [ADDR_W-1:0] tw
);

  logic [ADDR_W-1:0] tw_q;
  logic [ADDR_W-1:0] tw_d;
  logic [ADDR_W:0]   sum;

  // Next twiddle index; the extra sum bit keeps N=4095 from overflowing.
  always_comb begin
    sum  = {1'b0, tw_q} + {1'b0, k};
    tw_d = tw_q;
    if (clear) begin
      tw_d = '0;
    end else if (step) begin
      if (sum >= {1'b0, N}) begin
        tw_d = ADDR_W'(sum - {1'b0, N});
      end else begin
        tw_d = sum[ADDR_W-1:0];
      end
    end
  end

  // Twiddle index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw_q <= '0;
    end else begin
      tw_q <= tw_d;
    end
  end

  assign tw = tw_q;

endmodule

// File: rtl/dft_sequencer.sv
// DFT address sequencer: for each bin k it clears the accumulator, streams N
// sample/twiddle address pairs, waits out the MAC latency and writes bin k.
// Optional macro DFT_SEQ_HALF_SPECTRUM_EN limits the bins to 0..floor(N/2).
module dft_sequencer
  import fft_pkg::*;
#(
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic [ADDR_W-1:0] sample_num,
  input  logic              res_ready,
  output logic [ADDR_W-1:0] sample_adr,
  output logic [ADDR_W-1:0] tw_adr,
  output logic              acc_clear,
  output logic              acc_en,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_adr,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] DRAIN_LAST = 8'(MAC_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] n_len_q, n_len_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [7:0]        drain_q, drain_d;
  logic              acc_clear_q, acc_clear_d;
  logic              acc_en_q, acc_en_d;
  logic              res_we_q, res_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tw_clear, tw_step;
  logic [ADDR_W-1:0] k_last;

  // Last bin to compute: all N bins, or only the non-redundant half.
  always_comb begin
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
    k_last = {1'b0, n_len_q[ADDR_W-1:1]};
`else
    k_last = n_len_q - 12'd1;
`endif
  end

  // Next-state and next-output logic; with ce low every register holds.
  always_comb begin
    state_d     = state_q;
    n_len_d     = n_len_q;
    k_d         = k_q;
    n_d         = n_q;
    drain_d     = drain_q;
    acc_clear_d = acc_clear_q;
    acc_en_d    = acc_en_q;
    res_we_d    = res_we_q;
    done_d      = done_q;
    tw_clear    = 1'b0;
    tw_step     = 1'b0;
    if (ce) begin
      acc_clear_d = 1'b0;
      acc_en_d    = 1'b0;
      res_we_d    = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && (sample_num >= 12'd2)) begin
            n_len_d     = sample_num;
            k_d         = '0;
            acc_clear_d = 1'b1;
            state_d     = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          n_d      = '0;
          tw_clear = 1'b1;
          acc_en_d = 1'b1;
          state_d  = ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (n_q == n_len_q - 12'd1) begin
            drain_d = '0;
            if (MAC_LAT == 0) begin
              res_we_d = 1'b1;
              state_d  = ST_WRITE;
            end else begin
              state_d  = ST_DRAIN;
            end
          end else begin
            n_d      = n_q + 12'd1;
            tw_step  = 1'b1;
            acc_en_d = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            res_we_d = 1'b1;
            state_d  = ST_WRITE;
          end else begin
            drain_d = drain_q + 8'd1;
          end
        end
        ST_WRITE: begin
          if (res_ready) begin
            if (k_q == k_last) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              k_d         = k_q + 12'd1;
              acc_clear_d = 1'b1;
              state_d     = ST_CLEAR;
            end
          end else begin
            res_we_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_len_q     <= '0;
      k_q         <= '0;
      n_q         <= '0;
      drain_q     <= '0;
      acc_clear_q <= 1'b0;
      acc_en_q    <= 1'b0;
      res_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_len_q     <= n_len_d;
      k_q         <= k_d;
      n_q         <= n_d;
      drain_q     <= drain_d;
      acc_clear_q <= acc_clear_d;
      acc_en_q    <= acc_en_d;
      res_we_q    <= res_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  tw_adr_gen u_tw_adr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (tw_clear),
    .step  (tw_step),
    .k     (k_q),
    .N     (n_len_q),
    .tw    (tw_adr)
  );

  assign sample_adr = n_q;
  assign res_adr    = k_q;
  assign acc_clear  = acc_clear_q;
  assign acc_en     = acc_en_q;
  assign res_we     = res_we_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dft_sequencer.sv
// Testbench for dft_sequencer: a loop-based transform model predicts the
// outputs after every enabled clock edge; directed runs pin the model with
// hand-computed sequences, then randomized ce/res_ready/start traffic follows.
module tb_dft_sequencer;

  localparam int MAC_LAT = 2;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        start;
  logic [11:0] sample_num;
  logic        res_ready;
  logic [11:0] sample_adr;
  logic [11:0] tw_adr;
  logic        acc_clear;
  logic        acc_en;
  logic        res_we;
  logic [11:0] res_adr;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 0;

  // model state
  bit exp_busy, exp_clear, exp_en, exp_we, exp_done;
  int exp_sa, exp_tw, exp_ra;
  int mdl_edges = 0;
  bit aborted = 0;
  bit s_start, s_ready;
  int s_num;

  // capture for hand-computed checks
  bit cap_on = 0;
  int cap_dut[$];
  int cap_mdl[$];
  int wr_q[$];
  int last_edges = 0;

  dft_sequencer #(.MAC_LAT(MAC_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .start      (start),
    .sample_num (sample_num),
    .res_ready  (res_ready),
    .sample_adr (sample_adr),
    .tw_adr     (tw_adr),
    .acc_clear  (acc_clear),
    .acc_en     (acc_en),
    .res_we     (res_we),
    .res_adr    (res_adr),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic set_exp(input bit b, input bit c, input bit e, input bit w, input bit d);
    exp_busy  = b;
    exp_clear = c;
    exp_en    = e;
    exp_we    = w;
    exp_done  = d;
  endtask

  // Wait for the next clock edge that the design acts on; reset aborts.
  task automatic adv();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        aborted = 1;
        set_exp(0, 0, 0, 0, 0);
        wait (rst == 1'b0);
      end else if (ce) begin
        s_start = start;
        s_num   = int'(sample_num);
        s_ready = res_ready;
        mdl_edges++;
        break;
      end
    end
  endtask

  // Transform model: nested loops over bins and samples, tw = (n*k) mod N.
  initial begin : model_proc
    int n_len;
    int k_last;
    bit got;
    set_exp(0, 0, 0, 0, 0);
    exp_sa = 0; exp_tw = 0; exp_ra = 0;
    forever begin
      got = 0;
      while (!got) begin
        adv();
        aborted  = 0;
        exp_done = 0;
        if (s_start && s_num >= 2) got = 1;
      end
      n_len = s_num;
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
      k_last = n_len / 2;
`else
      k_last = n_len - 1;
`endif
      set_exp(1, 1, 0, 0, 0);
      for (int k = 0; k <= k_last && !aborted; k++) begin
        for (int n = 0; n < n_len && !aborted; n++) begin
          adv();
          if (!aborted) begin
            set_exp(1, 0, 1, 0, 0);
            exp_sa = n;
            exp_tw = (n * k) % n_len;
          end
        end
        for (int d = 0; d < MAC_LAT && !aborted; d++) begin
          adv();
          if (!aborted) set_exp(1, 0, 0, 0, 0);
        end
        if (!aborted) begin
          adv();
          if (!aborted) begin
            set_exp(1, 0, 0, 1, 0);
            exp_ra = k;
          end
        end
        while (!aborted) begin
          adv();
          if (aborted || s_ready) break;
        end
        if (!aborted) begin
          if (k == k_last) set_exp(0, 0, 0, 0, 1);
          else set_exp(1, 1, 0, 0, 0);
        end
      end
    end
  end

  // Compare DUT against the model on every cycle outside reset.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check_output("busy", int'(busy), int'(exp_busy));
      check_output("done", int'(done), int'(exp_done));
      check_output("acc_clear", int'(acc_clear), int'(exp_clear));
      check_output("acc_en", int'(acc_en), int'(exp_en));
      check_output("res_we", int'(res_we), int'(exp_we));
      if (exp_en) begin
        check_output("sample_adr", int'(sample_adr), exp_sa);
        check_output("tw_adr", int'(tw_adr), exp_tw);
      end
      if (exp_we) check_output("res_adr", int'(res_adr), exp_ra);
      if (mdl_edges != last_edges) begin
        last_edges = mdl_edges;
        if (cap_on && exp_en) begin
          cap_dut.push_back(int'(tw_adr));
          cap_mdl.push_back(exp_tw);
        end
      end
    end
  end

  task automatic apply_stimulus();
    ce         = ($urandom % 5) != 0;
    res_ready  = ($urandom % 3) != 0;
    start      = ($urandom % 4) == 0;
    sample_num = 12'($urandom_range(0, 4095));
  endtask

  task automatic start_tx(input int n);
    bit seen;
    seen       = 0;
    ce         = 1;
    res_ready  = 1;
    sample_num = 12'(n);
    start      = 1;
    cap_dut.delete();
    cap_mdl.delete();
    wr_q.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1;
        break;
      end
    end
    start = 0;
    if (!seen) check_output("start_timeout", 0, 1);
  endtask

  task automatic wait_done(input bit rnd, input int budget, output int busy_cnt);
    bit seen;
    seen     = 0;
    busy_cnt = 0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_cnt++;
      if (rnd) apply_stimulus();
      if (res_we && res_ready && ce) wr_q.push_back(int'(res_adr));
      @(negedge clk);
    end
    start     = 0;
    ce        = 1;
    res_ready = 1;
    if (!seen) check_output("done_timeout", 0, 1);
  endtask

  initial begin : main_proc
    int bc;
    int clr;
    int held;
    bit found;
    int exp4[16];
    int exp5[5];
    rst = 1; ce = 1; start = 0; sample_num = 12'd0; res_ready = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_done", int'(done), 0);
    check_output("rst_acc_en", int'(acc_en), 0);
    check_output("rst_res_we", int'(res_we), 0);
    check_output("rst_sample_adr", int'(sample_adr), 0);
    check_output("rst_tw_adr", int'(tw_adr), 0);
    check_output("rst_res_adr", int'(res_adr), 0);
    chk_en = 1;

`ifndef DFT_SEQ_HALF_SPECTRUM_EN
    $display("[TB] N=4 full transform");
    exp4 = '{0,0,0,0, 0,1,2,3, 0,2,0,2, 0,3,2,1};
    cap_on = 1;
    start_tx(4);
    wait_done(0, 200, bc);
    cap_on = 0;
    check_output("n4_busy_cycles", bc, 32);
    check_output("n4_tw_count", cap_dut.size(), 16);
    for (int i = 0; i < 16 && i < cap_dut.size(); i++) begin
      check_output("n4_tw_dut", cap_dut[i], exp4[i]);
      check_output("n4_tw_model", cap_mdl[i], exp4[i]);
    end
    check_output("n4_writes", wr_q.size(), 4);
    for (int i = 0; i < wr_q.size(); i++) check_output("n4_res_adr", wr_q[i], i);

    $display("[TB] N=5 modulo stepping");
    exp5 = '{0,3,1,4,2};
    cap_on = 1;
    start_tx(5);
    wait_done(0, 200, bc);
    cap_on = 0;
    check_output("n5_tw_count", cap_dut.size(), 25);
    for (int i = 0; i < 5 && 15 + i < cap_dut.size(); i++) begin
      check_output("n5_k3_tw_dut", cap_dut[15 + i], exp5[i]);
      check_output("n5_k3_tw_model", cap_mdl[15 + i], exp5[i]);
    end
`else
    $display("[TB] N=8 half spectrum");
    start_tx(8);
    wait_done(0, 300, bc);
    check_output("n8_writes", wr_q.size(), 5);
    for (int i = 0; i < wr_q.size(); i++) check_output("n8_res_adr", wr_q[i], i);
    check_output("n8_busy_cycles", bc, 5 * 12);
`endif

    $display("[TB] res_ready backpressure");
    start_tx(3);
    res_ready = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (res_we) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check_output("bp_write_timeout", 0, 1);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_we && res_adr == 12'd0) held++;
      @(negedge clk);
    end
    check_output("bp_held_cycles", held, 10);
    res_ready = 1;
    @(negedge clk);
    check_output("bp_clear_after", int'(acc_clear), 1);
    wait_done(0, 200, bc);

    $display("[TB] ce freeze mid compute");
    start_tx(6);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (acc_en && sample_adr == 12'd2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check_output("freeze_timeout", 0, 1);
    ce = 0;
    repeat (5) @(negedge clk);
    check_output("freeze_sample_adr", int'(sample_adr), 2);
    ce = 1;
    wait_done(0, 400, bc);

    $display("[TB] reset mid transform");
    start_tx(4);
    clr = acc_clear ? 1 : 0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_clear) clr++;
      if (clr == 3 && acc_en && sample_adr == 12'd1) begin
        found = 1;
        break;
      end
    end
    if (!found) check_output("rst_mid_timeout", 0, 1);
    #2 rst = 1;
    #1;
    check_output("rst_async_busy", int'(busy), 0);
    check_output("rst_async_acc_en", int'(acc_en), 0);
    check_output("rst_async_sample_adr", int'(sample_adr), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_output("rst_no_resume", int'(busy), 0);
    start_tx(4);
    wait_done(0, 200, bc);
    check_output("restart_first_bin", (wr_q.size() > 0) ? wr_q[0] : -1, 0);
`ifdef DFT_SEQ_HALF_SPECTRUM_EN
    check_output("restart_busy_cycles", bc, 24);
`else
    check_output("restart_busy_cycles", bc, 32);
`endif

    $display("[TB] short length ignored");
    for (int s = 0; s < 2; s++) begin
      sample_num = 12'(s);
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (2) @(negedge clk);
      check_output("short_busy", int'(busy), 0);
    end

    $display("[TB] randomized transforms");
    for (int t = 0; t < 10; t++) begin
      start_tx($urandom_range(2, 12));
      wait_done(1, 3000, bc);
      sample_num = 12'($urandom_range(0, 1));
      start = 1;
      @(negedge clk);
      start = 0;
      @(negedge clk);
    end

    $display("[TB] N=4095 first bins");
    start_tx(4095);
    repeat (12400) @(negedge clk);
    check_output("big_still_busy", int'(busy), 1);
    #2 rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check_output("big_abort_busy", int'(busy), 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dft_sequencer.md
DFT_SEQUENCER -- requirements
Module: dft_sequencer

Interface
REQ-001 SHALL have parameter MAC_LAT, default 2, meaning MAC datapath latency in cycles from acc_en to a valid accumulator.
REQ-002 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port ce, input, 1 bit: clock enable; when low, all state, counters and outputs hold.
REQ-005 SHALL have port start, input, 1 bit: samples loaded, begin transform.
REQ-006 SHALL have port sample_num, input, 12 bits: transform length N, latched at start.
REQ-007 SHALL have port res_ready, input, 1 bit: result sink accepts the write.
REQ-008 SHALL have port sample_adr, output, 12 bits: sample index n.
REQ-009 SHALL have port tw_adr, output, 12 bits: twiddle index (n*k) mod N.
REQ-010 SHALL have port acc_clear, output, 1 bit: clear the accumulator.
REQ-011 SHALL have port acc_en, output, 1 bit: accumulate the product.
REQ-012 SHALL have port res_we, output, 1 bit: result write strobe.
REQ-013 SHALL have port res_adr, output, 12 bits: bin index k.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when the transform completes.

Function
REQ-016 SHALL implement states IDLE, CLEAR, COMPUTE, DRAIN and WRITE; all outputs SHALL be registered.
REQ-017 IDLE:
- Trigger: start=1, ce=1 and sample_num>=2.
- Actions: latch N=sample_num, set k=0, go to CLEAR.
- sample_num<2: start ignored, block stays in IDLE.
REQ-018 CLEAR:
- Asserts acc_clear for exactly one cycle.
- Sets n=0 and tw=0, then goes to COMPUTE.
REQ-019 COMPUTE:
- acc_en=1 every cycle.
- sample_adr=n, tw_adr=tw.
- Per cycle: n+=1; tw=tw+k, minus N if the sum is >=N (no multiplier, no divider).
REQ-020 COMPUTE SHALL last exactly N cycles; after the cycle with n=N-1 it goes to DRAIN and acc_en drops.
REQ-021 DRAIN SHALL wait exactly MAC_LAT cycles, then go to WRITE.
REQ-022 WRITE:
- Holds res_we=1 and res_adr=k until res_ready=1 is seen with ce=1.
- On that handshake, if k=K_last: go to IDLE and pulse done.
- Otherwise: k+=1 and go to CLEAR.
REQ-023 K_last SHALL be N-1.
REQ-024 Per-bin cycle count SHALL be 1+N+MAC_LAT+W, where W is the number of WRITE cycles (>=1).
REQ-025 start asserted while busy=1 SHALL be ignored; changes to sample_num while busy SHALL have no effect.
REQ-026 tw SHALL stay in [0,N-1] at all times, with no overflow at N=4095.

Reset
REQ-027 On rst=1 the block SHALL go to IDLE immediately (asynchronous), including mid-transform.
REQ-028 Reset values:
- Zero: sample_adr, tw_adr, res_adr, n, k, N, drain counter.
- Low: acc_clear, acc_en, res_we, busy, done.
REQ-029 After reset is released, the first action SHALL require a fresh start; no partial bin is resumed.

Configuration
REQ-030 With DFT_SEQ_HALF_SPECTRUM_EN defined, K_last SHALL be floor(N/2), computing bins 0..N/2 only (real-input symmetry).
REQ-031 Without DFT_SEQ_HALF_SPECTRUM_EN, K_last SHALL be N-1.

Structure
REQ-032 Package fft_pkg SHALL hold:
- the state enum type;
- ADDR_W=12;
- the MAC_LAT default.
REQ-033 Twiddle modulo stepping SHALL be sub-module tw_adr_gen: inputs clear, step, k, N; output tw.

Verification
REQ-034 N=4, MAC_LAT=2, res_ready tied 1, start pulse ->
- Bin k=1: tw_adr sequence 0,1,2,3; bin k=2: 0,2,0,2; bin k=3: 0,3,2,1.
- 4 res_we pulses with res_adr 0..3, then done pulse.
- Total 4*(1+4+2+1)=32 cycles.
REQ-035 N=5, k=3 -> tw_adr sequence 0,3,1,4,2 (non-power-of-two modulo).
REQ-036 res_ready held 0 for 10 cycles in WRITE of k=0 -> res_we and res_adr=0 held; k=1 CLEAR follows the first cycle with res_ready=1.
REQ-037 ce low for 5 cycles mid-COMPUTE (n=2) -> n, tw and outputs frozen; the remaining sequence is identical to an uninterrupted run.
REQ-038 Reset edges:
- rst pulse at n=1 of bin k=2 -> IDLE, busy=0 without a clock edge; a subsequent start restarts from k=0.
- start with sample_num=1 -> busy stays 0.
REQ-039 With DFT_SEQ_HALF_SPECTRUM_EN defined, N=8 -> res_adr 0..4 (5 writes), then done.
